// File: rtl/sopc_pkg.sv
// rtl/sopc_pkg.sv - shared opcodes, ALU ops, pipeline payloads and helpers for mips_sopc
package sopc_pkg;
  localparam int ROM_DEPTH_DEFAULT = 1024;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  localparam logic [5:0] OPC_SPECIAL = 6'h00, OPC_SPECIAL2 = 6'h1c;
  localparam logic [5:0] OPC_ADDI = 6'h08, OPC_ADDIU = 6'h09, OPC_SLTI = 6'h0a, OPC_SLTIU = 6'h0b;
  localparam logic [5:0] OPC_ANDI = 6'h0c, OPC_ORI = 6'h0d, OPC_XORI = 6'h0e, OPC_LUI = 6'h0f;
  localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_SRA = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04, FN_SRLV = 6'h06, FN_SRAV = 6'h07;
  localparam logic [5:0] FN_MFHI = 6'h10, FN_MTHI = 6'h11, FN_MFLO = 6'h12, FN_MTLO = 6'h13;
  localparam logic [5:0] FN_MULT = 6'h18, FN_MULTU = 6'h19;
  localparam logic [5:0] FN_ADD = 6'h20, FN_ADDU = 6'h21, FN_SUB = 6'h22, FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND = 6'h24, FN_OR = 6'h25, FN_XOR = 6'h26, FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2a, FN_SLTU = 6'h2b;
  localparam logic [5:0] FN2_MUL = 6'h02, FN2_CLZ = 6'h20, FN2_CLO = 6'h21;

  typedef enum logic [4:0] {
    OP_NOP, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_LUI, OP_SLL, OP_SRL, OP_SRA,
    OP_ADD, OP_ADDU, OP_SUB, OP_SUBU, OP_SLT, OP_SLTU, OP_CLZ, OP_CLO,
    OP_MUL, OP_MULT, OP_MULTU, OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO
  } alu_op_e;

  // Immediate operands (shamt or extended imm16) replace a or b via a_imm/b_imm.
  typedef struct packed {
    alu_op_e     op;
    logic        a_imm;
    logic        b_imm;
    logic [31:0] imm;
    logic [4:0]  a_idx;
    logic [4:0]  b_idx;
    logic [31:0] a_val;
    logic [31:0] b_val;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        wreg;
    logic [4:0]  wd;
    logic        whi;
    logic        wlo;
  } idex_t;

  typedef struct packed {
    logic        wreg;
    logic [4:0]  wd;
    logic [31:0] wdata;
    logic        whi;
    logic        wlo;
    logic [31:0] hi;
    logic [31:0] lo;
  } wb_t;

  function automatic logic [5:0] clz32(input logic [31:0] v);
    logic [5:0] n;
    n = 6'd32;
    for (int i = 0; i < 32; i++) if (v[i]) n = 6'(31 - i);
    return n;
  endfunction
endpackage

// File: rtl/mips_sopc_alu.sv
// rtl/mips_sopc_alu.sv - execute-stage datapath; multiplier present only with SOPC_MULT_EN
module mips_sopc_alu import sopc_pkg::*; (
  input  alu_op_e     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [31:0] result,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic        ovf
);
  logic [31:0] sum, diff;
  assign sum  = a + b;
  assign diff = a - b;
`ifdef SOPC_MULT_EN
  logic [63:0] sprod, uprod;
  assign sprod = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign uprod = {32'd0, a} * {32'd0, b};
`endif

  always_comb begin
    result = 32'd0;
    ovf    = 1'b0;
    hi_out = hi;
    lo_out = lo;
    case (op)
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NOR:  result = ~(a | b);
      OP_LUI:  result = b;
      OP_SLL:  result = b << a[4:0];
      OP_SRL:  result = b >> a[4:0];
      OP_SRA:  result = $signed(b) >>> a[4:0];
      OP_ADD:  begin result = sum;  ovf = (a[31] == b[31]) && (sum[31] != a[31]); end
      OP_ADDU: result = sum;
      OP_SUB:  begin result = diff; ovf = (a[31] != b[31]) && (diff[31] != a[31]); end
      OP_SUBU: result = diff;
      OP_SLT:  result = {31'd0, $signed(a) < $signed(b)};
      OP_SLTU: result = {31'd0, a < b};
      OP_CLZ:  result = {26'd0, clz32(a)};
      OP_CLO:  result = {26'd0, clz32(~a)};
      OP_MFHI: result = hi;
      OP_MFLO: result = lo;
      OP_MTHI: hi_out = a;
      OP_MTLO: lo_out = a;
`ifdef SOPC_MULT_EN
      OP_MUL:   result = sprod[31:0];
      OP_MULT:  {hi_out, lo_out} = sprod;
      OP_MULTU: {hi_out, lo_out} = uprod;
`endif
      default: ;
    endcase
  end
endmodule

// File: rtl/mips_sopc_cpu.sv
// rtl/mips_sopc_cpu.sv - 5-stage IF/ID/EX/MEM/WB integer pipeline; SOPC_MULT_EN enables mul/mult/multu decode
module mips_sopc_cpu import sopc_pkg::*; (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] instr,
  output logic [31:0] pc
);
  logic [31:0] ifid_instr;
  idex_t       id_dec, idex;
  wb_t         ex_out, exmem, memwb;
  logic [31:0] rs_val, rt_val, hi_val, lo_val;
  logic [31:0] ex_a, ex_b, ex_hi, ex_lo, ex_result, ex_hi_out, ex_lo_out;
  logic        ex_ovf;

  logic [5:0]  opc, fn;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm16;
  assign {opc, rs, rt, rd, shamt, fn} = ifid_instr;
  assign imm16 = ifid_instr[15:0];

  // Reset squashes the instruction sitting in WB as well.
  mips_sopc_regfile register (
    .clock(clock), .we(memwb.wreg & ~reset), .waddr(memwb.wd), .wdata(memwb.wdata),
    .raddr_a(rs), .raddr_b(rt), .rdata_a(rs_val), .rdata_b(rt_val)
  );

  mips_sopc_hilo hilo (
    .clock(clock), .reset(reset), .whi(memwb.whi), .wlo(memwb.wlo),
    .hi_in(memwb.hi), .lo_in(memwb.lo), .hi_out(hi_val), .lo_out(lo_val)
  );

  always_comb begin
    id_dec       = '0;
    id_dec.a_idx = rs;
    id_dec.b_idx = rt;
    id_dec.a_val = rs_val;
    id_dec.b_val = rt_val;
    id_dec.hi    = hi_val;
    id_dec.lo    = lo_val;
    case (opc)
      OPC_SPECIAL: begin
        id_dec.wd   = rd;
        id_dec.wreg = 1'b1;
        id_dec.imm  = {27'd0, shamt};
        case (fn)
          FN_SLL:   begin id_dec.op = OP_SLL; id_dec.a_imm = 1'b1; end
          FN_SRL:   begin id_dec.op = OP_SRL; id_dec.a_imm = 1'b1; end
          FN_SRA:   begin id_dec.op = OP_SRA; id_dec.a_imm = 1'b1; end
          FN_SLLV:  id_dec.op = OP_SLL;
          FN_SRLV:  id_dec.op = OP_SRL;
          FN_SRAV:  id_dec.op = OP_SRA;
          FN_MFHI:  id_dec.op = OP_MFHI;
          FN_MFLO:  id_dec.op = OP_MFLO;
          FN_MTHI:  begin id_dec.op = OP_MTHI; id_dec.wreg = 1'b0; id_dec.whi = 1'b1; end
          FN_MTLO:  begin id_dec.op = OP_MTLO; id_dec.wreg = 1'b0; id_dec.wlo = 1'b1; end
`ifdef SOPC_MULT_EN
          FN_MULT:  begin id_dec.op = OP_MULT;  id_dec.wreg = 1'b0; id_dec.whi = 1'b1; id_dec.wlo = 1'b1; end
          FN_MULTU: begin id_dec.op = OP_MULTU; id_dec.wreg = 1'b0; id_dec.whi = 1'b1; id_dec.wlo = 1'b1; end
`endif
          FN_ADD:   id_dec.op = OP_ADD;
          FN_ADDU:  id_dec.op = OP_ADDU;
          FN_SUB:   id_dec.op = OP_SUB;
          FN_SUBU:  id_dec.op = OP_SUBU;
          FN_AND:   id_dec.op = OP_AND;
          FN_OR:    id_dec.op = OP_OR;
          FN_XOR:   id_dec.op = OP_XOR;
          FN_NOR:   id_dec.op = OP_NOR;
          FN_SLT:   id_dec.op = OP_SLT;
          FN_SLTU:  id_dec.op = OP_SLTU;
          default:  id_dec.wreg = 1'b0;
        endcase
      end
      OPC_SPECIAL2: begin
        id_dec.wd   = rd;
        id_dec.wreg = 1'b1;
        case (fn)
          FN2_CLZ: id_dec.op = OP_CLZ;
          FN2_CLO: id_dec.op = OP_CLO;
`ifdef SOPC_MULT_EN
          FN2_MUL: id_dec.op = OP_MUL;
`endif
          default: id_dec.wreg = 1'b0;
        endcase
      end
      default: begin
        id_dec.wd    = rt;
        id_dec.wreg  = 1'b1;
        id_dec.b_imm = 1'b1;
        id_dec.imm   = {{16{imm16[15]}}, imm16};
        case (opc)
          OPC_ADDI:  id_dec.op = OP_ADD;
          OPC_ADDIU: id_dec.op = OP_ADDU;
          OPC_SLTI:  id_dec.op = OP_SLT;
          OPC_SLTIU: id_dec.op = OP_SLTU;
          OPC_ANDI:  begin id_dec.op = OP_AND; id_dec.imm = {16'd0, imm16}; end
          OPC_ORI:   begin id_dec.op = OP_OR;  id_dec.imm = {16'd0, imm16}; end
          OPC_XORI:  begin id_dec.op = OP_XOR; id_dec.imm = {16'd0, imm16}; end
          OPC_LUI:   begin id_dec.op = OP_LUI; id_dec.imm = {imm16, 16'd0}; end
          default:   id_dec.wreg = 1'b0;
        endcase
      end
    endcase
    id_dec.wreg = id_dec.wreg & (id_dec.wd != 5'd0);
  end

  // Producers one and two ahead are still in EX/MEM and MEM/WB; older ones were caught by write-through.
  function automatic logic [31:0] fwd(input logic [4:0] idx, input logic [31:0] val,
                                      input wb_t m1, input wb_t m2);
    if (m1.wreg && m1.wd == idx) return m1.wdata;
    if (m2.wreg && m2.wd == idx) return m2.wdata;
    return val;
  endfunction

  assign ex_a  = idex.a_imm ? idex.imm : fwd(idex.a_idx, idex.a_val, exmem, memwb);
  assign ex_b  = idex.b_imm ? idex.imm : fwd(idex.b_idx, idex.b_val, exmem, memwb);
  assign ex_hi = exmem.whi ? exmem.hi : memwb.whi ? memwb.hi : idex.hi;
  assign ex_lo = exmem.wlo ? exmem.lo : memwb.wlo ? memwb.lo : idex.lo;

  mips_sopc_alu alu (
    .op(idex.op), .a(ex_a), .b(ex_b), .hi(ex_hi), .lo(ex_lo),
    .result(ex_result), .hi_out(ex_hi_out), .lo_out(ex_lo_out), .ovf(ex_ovf)
  );

  always_comb begin
    ex_out.wreg  = idex.wreg & ~ex_ovf;
    ex_out.wd    = idex.wd;
    ex_out.wdata = ex_result;
    ex_out.whi   = idex.whi;
    ex_out.wlo   = idex.wlo;
    ex_out.hi    = ex_hi_out;
    ex_out.lo    = ex_lo_out;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc         <= 32'd0;
      ifid_instr <= NOP_INSTR;
      idex       <= '0;
      exmem      <= '0;
      memwb      <= '0;
    end else begin
      pc         <= pc + 32'd4;
      ifid_instr <= instr;
      idex       <= id_dec;
      exmem      <= ex_out;
      memwb      <= exmem;
    end
  end
endmodule

// File: rtl/mips_sopc_hilo.sv
// rtl/mips_sopc_hilo.sv - HI/LO pair with independent write enables and write-through reads
module mips_sopc_hilo (
  input  logic        clock,
  input  logic        reset,
  input  logic        whi,
  input  logic        wlo,
  input  logic [31:0] hi_in,
  input  logic [31:0] lo_in,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);
  logic [31:0] hi, lo;

  always_ff @(posedge clock) begin
    if (reset) begin
      hi <= 32'd0;
      lo <= 32'd0;
    end else begin
      if (whi) hi <= hi_in;
      if (wlo) lo <= lo_in;
    end
  end

  assign hi_out = whi ? hi_in : hi;
  assign lo_out = wlo ? lo_in : lo;
endmodule

// File: rtl/mips_sopc_regfile.sv
// rtl/mips_sopc_regfile.sv - 2R1W GPR file with write-through to same-cycle reads
module mips_sopc_regfile (
  input  logic        clock,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr_a,
  input  logic [4:0]  raddr_b,
  output logic [31:0] rdata_a,
  output logic [31:0] rdata_b
);
  logic [31:0] storage [0:31];

  always_ff @(posedge clock) begin
    if (we && waddr != 5'd0) storage[waddr] <= wdata;
  end

  assign rdata_a = (raddr_a == 5'd0) ? 32'd0 : (we && waddr == raddr_a) ? wdata : storage[raddr_a];
  assign rdata_b = (raddr_b == 5'd0) ? 32'd0 : (we && waddr == raddr_b) ? wdata : storage[raddr_b];
endmodule

// File: rtl/mips_sopc_rom.sv
// rtl/mips_sopc_rom.sv - combinational word-addressed instruction ROM, loaded externally
module mips_sopc_rom #(
  parameter int DEPTH = 1024
) (
  input  logic [31:0] pc,
  output logic [31:0] instr
);
  localparam int AW = $clog2(DEPTH);

  logic [31:0] storage [0:DEPTH-1];
  logic        unused_pc_bits;

  assign instr = storage[pc[AW+1:2]];
  assign unused_pc_bits = ^{pc[31:AW+2], pc[1:0]};
endmodule

// File: rtl/mips_sopc.sv
// rtl/mips_sopc.sv - MIPS32 ALU-subset SoC top: cpu plus instruction rom (SOPC_MULT_EN selects multiplier)
module mips_sopc import sopc_pkg::*; #(
  parameter int ROM_DEPTH = ROM_DEPTH_DEFAULT
) (
  input logic clock,
  input logic reset
);
  logic [31:0] pc, instr;

  mips_sopc_rom #(.DEPTH(ROM_DEPTH)) rom (.pc(pc), .instr(instr));

  mips_sopc_cpu cpu (.clock(clock), .reset(reset), .instr(instr), .pc(pc));
endmodule

// File: tb/tb_mips_sopc.sv
// tb/tb_mips_sopc.sv - directed program bench for mips_sopc with hierarchical state probes
module tb_mips_sopc;
  logic clock;
  logic reset;
  int   checks;
  int   failures;
  int   edges;

  mips_sopc dut (.clock(clock), .reset(reset));

  initial clock = 1'b0;
  always #5 clock = ~clock;

`ifdef SOPC_MULT_EN
  localparam logic [31:0] MUL_RES = 32'hFFFF_FFE2, MULT_HI = 32'hFFFF_FFFF, MULT_LO = 32'hFFFF_FFE2;
  localparam logic [31:0] MULTU_HI = 32'h0000_0005, MULTU_LO = 32'hFFFF_FFE2;
`else
  localparam logic [31:0] MUL_RES = 32'hFFFF_8000, MULT_HI = 32'h0, MULT_LO = 32'h0;
  localparam logic [31:0] MULTU_HI = 32'h0, MULTU_LO = 32'h0;
`endif

  function automatic logic [31:0] enc_r(input int op, input int fn, input int rs, input int rt,
                                        input int rd, input int sh);
    return {6'(op), 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
  endfunction

  function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reg(input int r, input logic [31:0] exp);
    check($sformatf("gpr%0d@edge%0d", r, edges), dut.cpu.register.storage[r], exp);
  endtask

  task automatic wait_edge(input int e);
    while (edges < e) begin
      @(posedge clock);
      edges++;
    end
    @(negedge clock);
  endtask

  logic [31:0] prog [0:43];

  initial begin
    checks = 0;
    failures = 0;
    edges = 0;
    reset = 1'b1;

    prog[0]  = enc_i(6'h0d, 0, 1, 16'h8000);
    prog[1]  = enc_r(0, 6'h00, 0, 1, 1, 16);
    prog[2]  = enc_i(6'h0d, 1, 1, 16'h0010);
    prog[3]  = enc_i(6'h0d, 0, 2, 16'h8000);
    prog[4]  = enc_r(0, 6'h00, 0, 2, 2, 16);
    prog[5]  = enc_i(6'h0d, 2, 2, 1);
    prog[6]  = enc_r(0, 6'h21, 2, 1, 3, 0);
    prog[7]  = enc_r(0, 6'h20, 2, 1, 3, 0);
    prog[8]  = enc_r(0, 6'h23, 1, 2, 3, 0);
    prog[9]  = enc_r(0, 6'h23, 3, 3, 3, 0);
    prog[10] = enc_i(6'h08, 3, 3, 16'h8000);
    prog[11] = enc_i(6'h0f, 0, 4, 16'hFFFF);
    prog[12] = enc_i(6'h0d, 0, 5, 16'hFFFF);
    prog[13] = enc_r(0, 6'h2a, 4, 5, 6, 0);
    prog[14] = enc_r(0, 6'h2b, 4, 5, 7, 0);
    prog[15] = enc_r(6'h1c, 6'h20, 0, 8, 8, 0);
    prog[16] = enc_r(0, 6'h27, 0, 0, 9, 0);
    prog[17] = enc_r(6'h1c, 6'h21, 9, 10, 10, 0);
    prog[18] = enc_i(6'h0f, 0, 11, 16'hA100);
    prog[19] = enc_r(6'h1c, 6'h20, 11, 12, 12, 0);
    prog[20] = enc_r(6'h1c, 6'h21, 11, 13, 13, 0);
    prog[21] = enc_i(6'h0f, 0, 14, 16'h1100);
    prog[22] = enc_r(6'h1c, 6'h20, 14, 15, 15, 0);
    prog[23] = enc_i(6'h09, 0, 16, 16'hFFFB);
    prog[24] = enc_i(6'h09, 0, 17, 6);
    prog[25] = enc_r(6'h1c, 6'h02, 16, 17, 3, 0);
    prog[26] = enc_r(0, 6'h18, 16, 17, 0, 0);
    prog[27] = enc_r(0, 6'h19, 16, 17, 0, 0);
    prog[28] = enc_r(0, 6'h11, 5, 0, 0, 0);
    prog[29] = enc_r(0, 6'h12, 0, 0, 19, 0);
    prog[30] = enc_r(0, 6'h10, 0, 0, 20, 0);
    prog[31] = enc_r(0, 6'h13, 4, 0, 0, 0);
    prog[32] = enc_r(0, 6'h12, 0, 0, 21, 0);
    prog[33] = enc_r(0, 6'h03, 0, 4, 22, 4);
    prog[34] = enc_r(0, 6'h06, 5, 4, 23, 0);
    prog[35] = enc_r(0, 6'h26, 4, 5, 24, 0);
    prog[36] = enc_i(6'h0e, 0, 25, 16'h8000);
    prog[37] = enc_i(6'h0a, 4, 26, 16'hFFFF);
    prog[38] = enc_i(6'h0b, 5, 27, 16'h8000);
    prog[39] = enc_r(0, 6'h22, 5, 4, 28, 0);
    prog[40] = 32'hFC01_0005;
    prog[41] = enc_i(6'h0d, 0, 0, 5);
    prog[42] = enc_r(0, 6'h21, 0, 0, 29, 0);
    prog[43] = enc_i(6'h0d, 0, 29, 16'h1234);
    for (int i = 0; i < 64; i++) dut.rom.storage[i] = 32'h0;
    for (int i = 0; i < 44; i++) dut.rom.storage[i] = prog[i];

    repeat (10) @(posedge clock);
    @(negedge clock);
    check("reset_pc", dut.cpu.pc, 32'h0);
    check("reset_hi", dut.cpu.hilo.hi, 32'h0);
    check("reset_lo", dut.cpu.hilo.lo, 32'h0);
    reset = 1'b0;

    wait_edge(1);  check("pc_after_edge1", dut.cpu.pc, 32'h4);
    wait_edge(5);  check_reg(1, 32'h0000_8000);
    wait_edge(6);  check_reg(1, 32'h8000_0000);
    wait_edge(7);  check_reg(1, 32'h8000_0010);
    check("hi_idle", dut.cpu.hilo.hi, 32'h0);
    check("lo_idle", dut.cpu.hilo.lo, 32'h0);
    wait_edge(10); check_reg(2, 32'h8000_0001);
    wait_edge(11); check_reg(3, 32'h0000_0011);
    wait_edge(12); check_reg(3, 32'h0000_0011);
    wait_edge(13); check_reg(3, 32'h0000_000F);
    wait_edge(14); check_reg(3, 32'h0000_0000);
    wait_edge(15); check_reg(3, 32'hFFFF_8000);
    wait_edge(18); check_reg(6, 32'h1);
    wait_edge(19); check_reg(7, 32'h0);
    wait_edge(20); check_reg(8, 32'h20);
    wait_edge(22); check_reg(10, 32'h20);
    wait_edge(24); check_reg(12, 32'h0);
    wait_edge(25); check_reg(13, 32'h1);
    wait_edge(27); check_reg(15, 32'h3);
    wait_edge(28); check_reg(16, 32'hFFFF_FFFB);
    wait_edge(30); check_reg(3, MUL_RES);
    wait_edge(31);
    check("mult_hi", dut.cpu.hilo.hi, MULT_HI);
    check("mult_lo", dut.cpu.hilo.lo, MULT_LO);
    wait_edge(32);
    check("multu_hi", dut.cpu.hilo.hi, MULTU_HI);
    check("multu_lo", dut.cpu.hilo.lo, MULTU_LO);
    wait_edge(33);
    check("mthi_hi", dut.cpu.hilo.hi, 32'h0000_FFFF);
    check("mthi_lo_kept", dut.cpu.hilo.lo, MULTU_LO);
    wait_edge(34); check_reg(19, MULTU_LO);
    wait_edge(35); check_reg(20, 32'h0000_FFFF);
    wait_edge(36); check("mtlo_lo", dut.cpu.hilo.lo, 32'hFFFF_0000);
    wait_edge(37); check_reg(21, 32'hFFFF_0000);
    wait_edge(38); check_reg(22, 32'hFFFF_F000);
    wait_edge(39); check_reg(23, 32'h1);
    wait_edge(40); check_reg(24, 32'hFFFF_FFFF);
    wait_edge(41); check_reg(25, 32'h0000_8000);
    wait_edge(42); check_reg(26, 32'h1);
    wait_edge(43); check_reg(27, 32'h1);
    wait_edge(44); check_reg(28, 32'h0001_FFFF);
    wait_edge(45); check_reg(1, 32'h8000_0010);
    wait_edge(47); check_reg(29, 32'h0);

    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_reg(29, 32'h0);
    check_reg(1, 32'h8000_0010);
    check("midreset_pc", dut.cpu.pc, 32'h0);
    check("midreset_hi", dut.cpu.hilo.hi, 32'h0);
    check("midreset_lo", dut.cpu.hilo.lo, 32'h0);
    reset = 1'b0;
    edges = 0;
    wait_edge(1); check("restart_pc", dut.cpu.pc, 32'h4);
    wait_edge(4); check_reg(1, 32'h8000_0010);
    wait_edge(5); check_reg(1, 32'h0000_8000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
